// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter: word and byte-enable types,
// arbiter state encoding and the wait-counter sizing helper.
package mem_arbiter_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } lc3b_arb_state;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arb_side_e;

  localparam lc3b_mem_wmask WMASK_FULL = 2'b11;

  // Width of a counter that can hold 0..t; a disabled timeout still needs one bit.
  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select between the I and D requesters.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter bit D_PRIORITY = 1'b1
) (
  input  logic      i_req,
  input  logic      d_req,
  input  arb_side_e last_grant,
  output logic      grant_i,
  output logic      grant_d
);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req && d_req) begin
      // On a tie, round-robin hands the port to whoever did not have it last.
      if (D_PRIORITY || (last_grant == SIDE_I)) begin
        grant_d = 1'b1;
      end else begin
        grant_i = 1'b1;
      end
    end else begin
      grant_i = i_req;
      grant_d = d_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical memory port between instruction fetch (I) and data (D):
// grants one side, registers its command, drives it until pmem_resp, routes the response back.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int D_PRIORITY = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_read,
  input  lc3b_word      i_addr,
  output logic          i_resp,
  output lc3b_word      i_rdata,
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_word      d_addr,
  input  lc3b_word      d_wdata,
  input  lc3b_mem_wmask d_wmask,
  output logic          d_resp,
  output lc3b_word      d_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_addr,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_wmask,
  input  logic          pmem_resp,
  input  lc3b_word      pmem_rdata,
  output logic          timeout_err,
  output lc3b_arb_state state
);

  // Handshake: a requester raises read/write with stable operands and holds it until the
  // matching *_resp pulse; only IDLE samples requests, and nothing is preempted once granted.

  localparam int             CNT_W     = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  arb_side_e        last_grant;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             i_req;
  logic             d_req;
  logic             grant_i;
  logic             grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  arb_pick #(
    .D_PRIORITY(D_PRIORITY != 0)
  ) u_pick (
    .i_req     (i_req),
    .d_req     (d_req),
    .last_grant(last_grant),
    .grant_i   (grant_i),
    .grant_d   (grant_d)
  );

  assign cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      pmem_read   <= 1'b0;
      pmem_write  <= 1'b0;
      pmem_addr   <= '0;
      pmem_wdata  <= '0;
      pmem_wmask  <= WMASK_FULL;
      last_grant  <= SIDE_D;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            // A D request with both strobes high is treated as a write.
            state      <= ARB_GRANT_D;
            pmem_read  <= ~d_write;
            pmem_write <= d_write;
            pmem_addr  <= d_addr;
            pmem_wdata <= d_wdata;
            pmem_wmask <= d_write ? d_wmask : WMASK_FULL;
            last_grant <= SIDE_D;
            wait_cnt   <= '0;
          end else if (grant_i) begin
            state      <= ARB_GRANT_I;
            pmem_read  <= 1'b1;
            pmem_write <= 1'b0;
            pmem_addr  <= i_addr;
            pmem_wdata <= '0;
            pmem_wmask <= WMASK_FULL;
            last_grant <= SIDE_I;
            wait_cnt   <= '0;
          end
        end
        ARB_GRANT_I, ARB_GRANT_D: begin
          if (pmem_resp) begin
            state      <= ARB_IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end else begin
            // A stalled access keeps going; the error is only a sticky flag.
            wait_cnt <= cnt_inc;
            if ((TIMEOUT > 0) && (cnt_inc >= CNT_LIMIT)) begin
              timeout_err <= 1'b1;
            end
          end
        end
        default: begin
          state      <= ARB_IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  assign i_resp  = (state == ARB_GRANT_I) && pmem_resp;
  assign d_resp  = (state == ARB_GRANT_D) && pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table on a D-priority instance, plus hand
// sequences for reset mid-access, operand hold, round-robin order and timeout.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          i_read;
  lc3b_word      i_addr;
  logic          d_read;
  logic          d_write;
  lc3b_word      d_addr;
  lc3b_word      d_wdata;
  lc3b_mem_wmask d_wmask;
  logic          pmem_resp;
  lc3b_word      pmem_rdata;

  logic          a_i_resp, a_d_resp, a_pmem_read, a_pmem_write, a_timeout_err;
  lc3b_word      a_i_rdata, a_d_rdata, a_pmem_addr, a_pmem_wdata;
  lc3b_mem_wmask a_pmem_wmask;
  lc3b_arb_state a_state;

  logic          b_i_resp, b_d_resp, b_pmem_read, b_pmem_write, b_timeout_err;
  lc3b_word      b_i_rdata, b_d_rdata, b_pmem_addr, b_pmem_wdata;
  lc3b_mem_wmask b_pmem_wmask;
  lc3b_arb_state b_state;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.D_PRIORITY(1), .TIMEOUT(4)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_resp(a_i_resp), .i_rdata(a_i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_resp(a_d_resp), .d_rdata(a_d_rdata),
    .pmem_read(a_pmem_read), .pmem_write(a_pmem_write), .pmem_addr(a_pmem_addr),
    .pmem_wdata(a_pmem_wdata), .pmem_wmask(a_pmem_wmask),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .timeout_err(a_timeout_err), .state(a_state)
  );

  mem_arbiter #(.D_PRIORITY(0), .TIMEOUT(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_resp(b_i_resp), .i_rdata(b_i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_resp(b_d_resp), .d_rdata(b_d_rdata),
    .pmem_read(b_pmem_read), .pmem_write(b_pmem_write), .pmem_addr(b_pmem_addr),
    .pmem_wdata(b_pmem_wdata), .pmem_wmask(b_pmem_wmask),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .timeout_err(b_timeout_err), .state(b_state)
  );

  // Clock / reset / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach summary, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          i_read;
    lc3b_word      i_addr;
    logic          d_read;
    logic          d_write;
    lc3b_word      d_addr;
    lc3b_word      d_wdata;
    lc3b_mem_wmask d_wmask;
    logic          pmem_resp;
    lc3b_word      pmem_rdata;
    logic          e_read;
    logic          e_write;
    lc3b_word      e_addr;
    lc3b_word      e_wdata;
    lc3b_mem_wmask e_wmask;
    logic          e_i_resp;
    logic          e_d_resp;
    lc3b_word      e_rdata;
    lc3b_arb_state e_state;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ir, input lc3b_word ia,
    input logic dr, input logic dw, input lc3b_word da, input lc3b_word dwd, input lc3b_mem_wmask dm,
    input logic pr, input lc3b_word prd,
    input logic er, input logic ew, input lc3b_word ea, input lc3b_word ewd, input lc3b_mem_wmask em,
    input logic eir, input logic edr, input lc3b_word erd, input lc3b_arb_state es);
    vec_t v;
    v.i_read = ir; v.i_addr = ia;
    v.d_read = dr; v.d_write = dw; v.d_addr = da; v.d_wdata = dwd; v.d_wmask = dm;
    v.pmem_resp = pr; v.pmem_rdata = prd;
    v.e_read = er; v.e_write = ew; v.e_addr = ea; v.e_wdata = ewd; v.e_wmask = em;
    v.e_i_resp = eir; v.e_d_resp = edr; v.e_rdata = erd; v.e_state = es;
    return v;
  endfunction

  // Driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
  endtask

  task automatic drive(input vec_t t);
    i_read = t.i_read; i_addr = t.i_addr;
    d_read = t.d_read; d_write = t.d_write; d_addr = t.d_addr;
    d_wdata = t.d_wdata; d_wmask = t.d_wmask;
    pmem_resp = t.pmem_resp; pmem_rdata = t.pmem_rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_state",    32'(a_state), 32'(ARB_IDLE));
    check("rst_read",     32'(a_pmem_read), 32'd0);
    check("rst_write",    32'(a_pmem_write), 32'd0);
    check("rst_addr",     32'(a_pmem_addr), 32'd0);
    check("rst_wdata",    32'(a_pmem_wdata), 32'd0);
    check("rst_wmask",    32'(a_pmem_wmask), 32'h3);
    check("rst_timeout",  32'(a_timeout_err), 32'd0);
    check("rst_rr_state", 32'(b_state), 32'(ARB_IDLE));
    rst_n = 1'b1;
    next_cycle();
  endtask

  logic [0:0] exp_q[$];
  logic [0:0] exp_p[$];

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // I read, pmem_resp in IDLE, simultaneous D-priority, write-wins, D read mask.
    vecs.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b11, 0, 0, 16'h0000, ARB_IDLE));
    vecs.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 2'b11, 0, 0, 16'h0000, ARB_GRANT_I));
    vecs.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 2'b11, 0, 0, 16'h0000, ARB_GRANT_I));
    vecs.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h1234, 1, 0, 16'h0040, 16'h0000, 2'b11, 1, 0, 16'h1234, ARB_GRANT_I));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h9999, 0, 0, 16'h0040, 16'h0000, 2'b11, 0, 0, 16'h0000, ARB_IDLE));
    vecs.push_back(mk(1, 16'h0010, 0, 1, 16'h0200, 16'hBEEF, 2'b01, 0, 16'h0000, 0, 0, 16'h0040, 16'h0000, 2'b11, 0, 0, 16'h0000, ARB_IDLE));
    vecs.push_back(mk(1, 16'h0010, 0, 1, 16'h0200, 16'hBEEF, 2'b01, 1, 16'h5555, 0, 1, 16'h0200, 16'hBEEF, 2'b01, 0, 1, 16'h5555, ARB_GRANT_D));
    vecs.push_back(mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0200, 16'hBEEF, 2'b01, 0, 0, 16'h0000, ARB_IDLE));
    vecs.push_back(mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h0ABC, 1, 0, 16'h0010, 16'h0000, 2'b11, 1, 0, 16'h0ABC, ARB_GRANT_I));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0010, 16'h0000, 2'b11, 0, 0, 16'h0000, ARB_IDLE));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h0300, 16'h1111, 2'b10, 0, 16'h0000, 0, 0, 16'h0010, 16'h0000, 2'b11, 0, 0, 16'h0000, ARB_IDLE));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h0300, 16'h1111, 2'b10, 1, 16'h2222, 0, 1, 16'h0300, 16'h1111, 2'b10, 0, 1, 16'h2222, ARB_GRANT_D));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0300, 16'h1111, 2'b10, 0, 0, 16'h0000, ARB_IDLE));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0400, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0300, 16'h1111, 2'b10, 0, 0, 16'h0000, ARB_IDLE));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0400, 16'h0000, 2'b00, 1, 16'h3333, 1, 0, 16'h0400, 16'h0000, 2'b11, 0, 1, 16'h3333, ARB_GRANT_D));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0400, 16'h0000, 2'b11, 0, 0, 16'h0000, ARB_IDLE));

    do_reset();
    foreach (vecs[k]) begin
      drive(vecs[k]);
      @(negedge clk);
      check($sformatf("v%0d_state", k),  32'(a_state), 32'(vecs[k].e_state));
      check($sformatf("v%0d_read", k),   32'(a_pmem_read), 32'(vecs[k].e_read));
      check($sformatf("v%0d_write", k),  32'(a_pmem_write), 32'(vecs[k].e_write));
      check($sformatf("v%0d_addr", k),   32'(a_pmem_addr), 32'(vecs[k].e_addr));
      check($sformatf("v%0d_wdata", k),  32'(a_pmem_wdata), 32'(vecs[k].e_wdata));
      check($sformatf("v%0d_wmask", k),  32'(a_pmem_wmask), 32'(vecs[k].e_wmask));
      check($sformatf("v%0d_i_resp", k), 32'(a_i_resp), 32'(vecs[k].e_i_resp));
      check($sformatf("v%0d_d_resp", k), 32'(a_d_resp), 32'(vecs[k].e_d_resp));
      if (vecs[k].e_i_resp) check($sformatf("v%0d_i_rdata", k), 32'(a_i_rdata), 32'(vecs[k].e_rdata));
      if (vecs[k].e_d_resp) check($sformatf("v%0d_d_rdata", k), 32'(a_d_rdata), 32'(vecs[k].e_rdata));
      next_cycle();
    end

    // Reset asserted while a D write is being strobed.
    do_reset();
    d_write = 1'b1; d_addr = 16'h0500; d_wdata = 16'hCAFE; d_wmask = 2'b11;
    next_cycle();
    @(negedge clk);
    check("mid_rst_pre_write", 32'(a_pmem_write), 32'd1);
    pmem_resp = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_write", 32'(a_pmem_write), 32'd0);
    check("mid_rst_d_resp", 32'(a_d_resp), 32'd0);
    check("mid_rst_state", 32'(a_state), 32'(ARB_IDLE));
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Operands change after grant; registered address must hold.
    do_reset();
    d_read = 1'b1; d_addr = 16'h0100;
    next_cycle();
    d_addr = 16'h0300;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("hold_addr_%0d", c), 32'(a_pmem_addr), 32'h0100);
      next_cycle();
    end
    pmem_resp = 1'b1; pmem_rdata = 16'h4444;
    @(negedge clk);
    check("hold_addr_resp", 32'(a_pmem_addr), 32'h0100);
    check("hold_d_resp", 32'(a_d_resp), 32'd1);
    check("hold_d_rdata", 32'(a_d_rdata), 32'h4444);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("hold_idle_state", 32'(a_state), 32'(ARB_IDLE));
    check("hold_idle_d_resp", 32'(a_d_resp), 32'd0);
    next_cycle();

    // Timeout: TIMEOUT=4 on dut_p, disabled on dut_rr.
    do_reset();
    d_read = 1'b1; d_addr = 16'h0600;
    next_cycle();
    for (int g = 1; g <= 6; g++) begin
      @(negedge clk);
      check($sformatf("to_state_%0d", g), 32'(a_state), 32'(ARB_GRANT_D));
      check($sformatf("to_err_%0d", g), 32'(a_timeout_err), (g >= 5) ? 32'd1 : 32'd0);
      check($sformatf("to_rr_err_%0d", g), 32'(b_timeout_err), 32'd0);
      next_cycle();
    end
    pmem_resp = 1'b1; pmem_rdata = 16'h7777;
    @(negedge clk);
    check("to_d_resp", 32'(a_d_resp), 32'd1);
    check("to_d_rdata", 32'(a_d_rdata), 32'h7777);
    next_cycle();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("to_sticky_%0d", c), 32'(a_timeout_err), 32'd1);
      next_cycle();
    end
    check("to_idle_state", 32'(a_state), 32'(ARB_IDLE));

    // Continuous requests from both sides with zero-wait memory.
    do_reset();
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    exp_p = {1'b1, 1'b1, 1'b1, 1'b1};
    i_read = 1'b1; i_addr = 16'h0080;
    d_read = 1'b1; d_addr = 16'h0900;
    pmem_resp = 1'b1; pmem_rdata = 16'h0001;
    for (int c = 0; c < 20 && (exp_q.size() > 0 || exp_p.size() > 0); c++) begin
      @(negedge clk);
      if (b_i_resp || b_d_resp) begin
        if (exp_q.size() > 0) check($sformatf("rr_grant_%0d", c), 32'(b_d_resp), 32'(exp_q.pop_front()));
      end
      if (a_i_resp || a_d_resp) begin
        if (exp_p.size() > 0) check($sformatf("prio_grant_%0d", c), 32'(a_d_resp), 32'(exp_p.pop_front()));
      end
      next_cycle();
    end
    check("rr_all_grants_seen", 32'(exp_q.size()), 32'd0);
    check("prio_all_grants_seen", 32'(exp_p.size()), 32'd0);
    idle_inputs();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
